// File: rtl/sd_spi_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : sd_spi_arbiter                                               |
// | Description : Shares one SD-card SPI link (mode 0) between two byte-level  |
// |               requesters and runs the SPI shifter.                         |
// |               Port 0 (CPU-side DivMMC/Z-Controller) has priority over     |
// |               port 1 (background loader). Ownership lasts for a whole     |
// |               chip-select session, so the two ports never interleave      |
// |               bytes inside a session.                                     |
// | Parameters  : DIV     - clk28 cycles per SCK half-period (1..15)           |
// |               TIMEOUT - idle cycles an owner may hold CS (timeout build)   |
// | Build macro : SD_OWNER_TIMEOUT_EN - enables the owner idle timeout; when   |
// |               undefined the owner holds the card indefinitely and         |
// |               timeout_o is tied 0.                                        |
// | Ports       : clk28_i, rst_i (sync, active high)                           |
// |               reqN_cs_n_i/valid_i/wdata_i  -> requester N session + byte   |
// |               reqN_ready_o/rvalid_o/rdata_o <- handshake + received byte   |
// |               busy_o (shifter active), owner_o (00/01/10), timeout_o      |
// |               sd_miso_i, sd_mosi_o, sd_sck_o, sd_cs_o (active low)        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sd_spi_arbiter #(
    parameter int DIV     = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic       clk28_i,
    input  logic       rst_i,

    input  logic       req0_cs_n_i,
    input  logic       req0_valid_i,
    input  logic [7:0] req0_wdata_i,
    output logic       req0_ready_o,
    output logic       req0_rvalid_o,
    output logic [7:0] req0_rdata_o,

    input  logic       req1_cs_n_i,
    input  logic       req1_valid_i,
    input  logic [7:0] req1_wdata_i,
    output logic       req1_ready_o,
    output logic       req1_rvalid_o,
    output logic [7:0] req1_rdata_o,

    output logic       busy_o,
    output logic [1:0] owner_o,
    output logic       timeout_o,

    input  logic       sd_miso_i,
    output logic       sd_mosi_o,
    output logic       sd_sck_o,
    output logic       sd_cs_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_SHIFT = 2'd1;
    localparam logic [1:0] C_ST_DONE  = 2'd2;

    localparam logic [1:0] C_OWN_NONE = 2'b00;
    localparam logic [1:0] C_OWN_P0   = 2'b01;
    localparam logic [1:0] C_OWN_P1   = 2'b10;

    localparam logic [3:0] C_DIV_LAST  = 4'(DIV - 1);
    localparam logic [3:0] C_HALF_LAST = 4'd15;

    // Elaboration-time guards on the configuration.
    if (DIV < 1 || DIV > 15) begin : g_bad_div
        $error("sd_spi_arbiter: DIV must be in 1..15");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("sd_spi_arbiter: TIMEOUT must be at least 1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0] state_q,  state_d;
    logic [1:0] owner_q,  owner_d;
    logic       cs_q,     cs_d;
    logic       sck_q,    sck_d;
    logic       busy_q,   busy_d;
    logic       ready0_q, ready0_d;
    logic       ready1_q, ready1_d;
    logic       rvalid0_q, rvalid0_d;
    logic       rvalid1_q, rvalid1_d;
    logic [7:0] rdata0_q, rdata0_d;
    logic [7:0] rdata1_q, rdata1_d;
    // Transmit shifter; its MSB is the registered MOSI line. It refills
    // with ones, so the line idles high once the byte has been shifted out.
    logic [7:0] tx_q,     tx_d;
    logic [7:0] rx_q,     rx_d;
    logic [3:0] div_q,    div_d;
    logic [3:0] half_q,   half_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic       w_accept;
    logic [7:0] w_wdata;
    logic       w_own_cs_n;
    logic       w_tmo_fire;
    logic       w_elig0;
    logic       w_elig1;

    // ready_q is only ever set for the current owner while IDLE, so the
    // owner match here just selects which requester's valid counts.
    assign w_accept = (state_q == C_ST_IDLE) &&
                      (((owner_q == C_OWN_P0) && ready0_q && req0_valid_i) ||
                       ((owner_q == C_OWN_P1) && ready1_q && req1_valid_i));

    assign w_wdata    = (owner_q == C_OWN_P1) ? req1_wdata_i : req0_wdata_i;
    assign w_own_cs_n = (owner_q == C_OWN_P1) ? req1_cs_n_i  : req0_cs_n_i;

    // ------------------------------------------------------------------
    // Next-state logic: arbitration, release and the SPI shifter
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cs_d      = cs_q;
        sck_d     = sck_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        div_d     = div_q;
        half_d    = half_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;

        case (state_q)
            C_ST_IDLE: begin
                if (w_accept) begin
                    state_d = C_ST_SHIFT;
                    tx_d    = w_wdata;
                    sck_d   = 1'b0;
                    div_d   = 4'd0;
                    half_d  = 4'd0;
                end else if ((owner_q != C_OWN_NONE) && (w_own_cs_n || w_tmo_fire)) begin
                    // Release only; re-arbitration waits for the next
                    // cycle so CS is seen high for at least one cycle.
                    owner_d = C_OWN_NONE;
                    cs_d    = 1'b1;
                end else if (owner_q == C_OWN_NONE) begin
                    if (!req0_cs_n_i && w_elig0) begin
                        owner_d = C_OWN_P0;
                        cs_d    = 1'b0;
                    end else if (!req1_cs_n_i && w_elig1) begin
                        owner_d = C_OWN_P1;
                        cs_d    = 1'b0;
                    end
                end
            end

            C_ST_SHIFT: begin
                if (div_q == C_DIV_LAST) begin
                    div_d  = 4'd0;
                    half_d = half_q + 4'd1;
                    if (!sck_q) begin
                        // Rising edge: card output is stable, sample it.
                        sck_d = 1'b1;
                        rx_d  = {rx_q[6:0], sd_miso_i};
                    end else begin
                        // Falling edge: advance to the next MOSI bit.
                        sck_d = 1'b0;
                        tx_d  = {tx_q[6:0], 1'b1};
                        if (half_q == C_HALF_LAST) begin
                            state_d = C_ST_DONE;
                        end
                    end
                end else begin
                    div_d = div_q + 4'd1;
                end
            end

            C_ST_DONE: begin
                state_d = C_ST_IDLE;
                tx_d    = 8'hFF;
                if (owner_q == C_OWN_P1) begin
                    rvalid1_d = 1'b1;
                    rdata1_d  = rx_q;
                end else if (owner_q == C_OWN_P0) begin
                    rvalid0_d = 1'b1;
                    rdata0_d  = rx_q;
                end
            end

            default: begin
                state_d = C_ST_IDLE;
            end
        endcase
    end

    // Registered handshake outputs are derived from the next state so
    // that ready is visible in the same cycle the state/owner become valid.
    always_comb begin
        busy_d   = (state_d != C_ST_IDLE);
        ready0_d = (state_d == C_ST_IDLE) && (owner_d == C_OWN_P0) && !req0_cs_n_i;
        ready1_d = (state_d == C_ST_IDLE) && (owner_d == C_OWN_P1) && !req1_cs_n_i;
    end

    always_ff @(posedge clk28_i) begin
        if (rst_i) begin
            state_q   <= C_ST_IDLE;
            owner_q   <= C_OWN_NONE;
            cs_q      <= 1'b1;
            sck_q     <= 1'b0;
            busy_q    <= 1'b0;
            ready0_q  <= 1'b0;
            ready1_q  <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= 8'h00;
            rdata1_q  <= 8'h00;
            tx_q      <= 8'hFF;
            rx_q      <= 8'h00;
            div_q     <= 4'd0;
            half_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cs_q      <= cs_d;
            sck_q     <= sck_d;
            busy_q    <= busy_d;
            ready0_q  <= ready0_d;
            ready1_q  <= ready1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            div_q     <= div_d;
            half_q    <= half_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional owner idle timeout
    // ------------------------------------------------------------------
`ifdef SD_OWNER_TIMEOUT_EN
    localparam int C_TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(TIMEOUT - 1);

    logic [C_TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic               timeout_q, timeout_d;
    // A port that was timed out stays locked out until it lets go of
    // cs_n, so it cannot silently grab the card straight back.
    logic [1:0]         blocked_q, blocked_d;

    assign w_tmo_fire = (state_q == C_ST_IDLE) && (owner_q != C_OWN_NONE) &&
                        !w_accept && (tmo_cnt_q == C_TMO_LAST);
    assign w_elig0    = !blocked_q[0];
    assign w_elig1    = !blocked_q[1];

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (w_accept || (owner_d != owner_q)) begin
            tmo_cnt_d = '0;
        end else if ((state_q == C_ST_IDLE) && (owner_q != C_OWN_NONE)) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        timeout_d    = timeout_q | w_tmo_fire;
        blocked_d[0] = (w_tmo_fire && (owner_q == C_OWN_P0)) | (blocked_q[0] & !req0_cs_n_i);
        blocked_d[1] = (w_tmo_fire && (owner_q == C_OWN_P1)) | (blocked_q[1] & !req1_cs_n_i);
    end

    always_ff @(posedge clk28_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
            blocked_q <= 2'b00;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
            blocked_q <= blocked_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign w_tmo_fire = 1'b0;
    assign w_elig0    = 1'b1;
    assign w_elig1    = 1'b1;
    assign timeout_o  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req0_ready_o  = ready0_q;
    assign req0_rvalid_o = rvalid0_q;
    assign req0_rdata_o  = rdata0_q;
    assign req1_ready_o  = ready1_q;
    assign req1_rvalid_o = rvalid1_q;
    assign req1_rdata_o  = rdata1_q;
    assign busy_o        = busy_q;
    assign owner_o       = owner_q;
    assign sd_mosi_o     = tx_q[7];
    assign sd_sck_o      = sck_q;
    assign sd_cs_o       = cs_q;

endmodule
`default_nettype wire
